tx_interface: RTL and testbench

- Return-path counterpart of the RX-side operand interface.
- Waits for the ALU to finish, then latches the result byte and the flag bits.
- Pushes a response frame into the Tx FIFO: result byte first, then an optional status byte.
- Sits between the ALU outputs and the Tx FIFO write port; never writes while the FIFO reports full.

---
 rtl/tx_interface.sv | 104 ++++++++++
 tb/tb_tx_interface.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_interface.sv
// Return-path framer: latches an ALU result and its flags on the done strobe, then writes
// the result byte (and optionally a status byte) into the Tx FIFO, honouring FIFO full.
module tx_interface #(
   parameter int unsigned DATA_WIDTH = 8,  // must be >= 5 so the status byte fits
   parameter int unsigned SEND_FLAGS = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_alu_result,
   input  logic                  i_alu_zero,
   input  logic                  i_alu_carry,
   input  logic                  i_alu_overflow,
   input  logic                  i_alu_negative,
   input  logic                  i_alu_exception,
   input  logic                  i_alu_done,
   input  logic                  i_txff_full,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic                  o_txff_write,
   output logic                  o_busy,
   output logic                  o_overrun
);

   typedef enum logic [1:0] {
      StIdle,
      StSendRes,
      StSendFlg
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic [DATA_WIDTH-1:0] sts_q, sts_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  overrun_q, overrun_d;
   logic                  sending;

   assign sending = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      sts_d     = sts_q;
      hold_d    = hold_q;
      overrun_d = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (i_alu_done) begin
               res_d      = i_alu_result;
               sts_d      = '0;
               sts_d[4:0] = {i_alu_exception, i_alu_negative, i_alu_overflow,
                             i_alu_carry, i_alu_zero};
               state_d    = StSendRes;
            end
         end
         StSendRes: begin
            if (!i_txff_full) begin
               hold_d  = res_q;
               state_d = (SEND_FLAGS != 0) ? StSendFlg : StIdle;
            end
         end
         StSendFlg: begin
            if (!i_txff_full) begin
               hold_d  = sts_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A done strobe is only consumed in idle; the last write edge still counts as busy.
      if (i_alu_done && sending) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= StIdle;
         res_q     <= '0;
         sts_q     <= '0;
         hold_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         res_q     <= res_d;
         sts_q     <= sts_d;
         hold_q    <= hold_d;
         overrun_q <= overrun_d;
      end
   end

   // Strobe is combinational on full so a freshly full FIFO is never written.
   always_comb begin
      o_txff_write = sending && !i_txff_full;
      o_busy       = sending;
      o_overrun    = overrun_q;
      unique case (state_q)
         StSendRes: o_tx_data = res_q;
         StSendFlg: o_tx_data = sts_q;
         default:   o_tx_data = hold_q;
      endcase
   end

endmodule

// File: tb/tb_tx_interface.sv
// Scoreboard bench for tx_interface: a frame-level model predicts bytes, busy and overrun;
// a negedge monitor compares every FIFO write against the expected-byte queue.
module tb_tx_interface;
   localparam int unsigned W     = 8;
   localparam int          Depth = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] res;
   logic         zf, cf, vf, nf, ef, done;
   logic         full;
   logic [W-1:0] tx_data;
   logic         wr, busy, ovr;

   logic         d1_done;
   logic [W-1:0] d1_res, d1_data;
   logic         d1_wr, d1_busy, d1_ovr;

   int passed = 0;
   int total  = 0;

   // Reference model state
   int           pending = 0;
   bit           ovr_exp = 1'b0;
   logic [W-1:0] expq[$];
   logic [W-1:0] fifo[$];
   bit           rd_req = 1'b0;
   bit           seen_wr = 1'b0;
   logic [W-1:0] seen_data = '0;
   int           d1_wr_cnt = 0;

   bit           m_full, m_done, m_rd, m_rst, m_busy;
   logic [W-1:0] m_res, m_sts, m_exp;

   always #5 clk = ~clk;

   tx_interface #(.DATA_WIDTH(W), .SEND_FLAGS(1)) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_alu_result   (res),
      .i_alu_zero     (zf),
      .i_alu_carry    (cf),
      .i_alu_overflow (vf),
      .i_alu_negative (nf),
      .i_alu_exception(ef),
      .i_alu_done     (done),
      .i_txff_full    (full),
      .o_tx_data      (tx_data),
      .o_txff_write   (wr),
      .o_busy         (busy),
      .o_overrun      (ovr)
   );

   tx_interface #(.DATA_WIDTH(W), .SEND_FLAGS(0)) dut1 (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_alu_result   (d1_res),
      .i_alu_zero     (1'b0),
      .i_alu_carry    (1'b0),
      .i_alu_overflow (1'b0),
      .i_alu_negative (1'b0),
      .i_alu_exception(1'b0),
      .i_alu_done     (d1_done),
      .i_txff_full    (1'b0),
      .o_tx_data      (d1_data),
      .o_txff_write   (d1_wr),
      .o_busy         (d1_busy),
      .o_overrun      (d1_ovr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Frame-level model: a frame occupies the block until all its bytes are written,
   // one byte per edge with the FIFO not full; done is taken only with nothing pending.
   always @(posedge clk) begin
      m_full = full;
      m_done = done;
      m_rd   = rd_req;
      m_rst  = rst;
      m_res  = res;
      m_sts  = W'(int'(zf) + 2 * int'(cf) + 4 * int'(vf) + 8 * int'(nf) + 16 * int'(ef));
      if (m_rst) begin
         pending = 0;
         ovr_exp = 1'b0;
      end else begin
         m_busy = (pending > 0);
         if (m_busy && !m_full) pending--;
         if (m_done) begin
            if (!m_busy) begin
               pending = 2;
               expq.push_back(m_res);
               expq.push_back(m_sts);
            end else begin
               ovr_exp = 1'b1;
            end
         end
      end
      #1;
      if (seen_wr) fifo.push_back(seen_data);
      seen_wr = 1'b0;
      if (m_rd && fifo.size() > 0) void'(fifo.pop_front());
      full = (fifo.size() >= Depth);
   end

   always @(negedge clk) begin
      seen_wr = 1'b0;
      if (!rst) begin
         check("busy", 32'(busy), 32'(pending > 0));
         check("overrun", 32'(ovr), 32'(ovr_exp));
         check("wr_strobe", 32'(wr), 32'((pending > 0) && !full));
         if (wr) begin
            seen_wr   = 1'b1;
            seen_data = tx_data;
            if (expq.size() == 0) begin
               total++;
               $display("FAIL unexpected_wr: got write of %0h, expected no write", tx_data);
            end else begin
               m_exp = expq.pop_front();
               check("wr_data", 32'(tx_data), 32'(m_exp));
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && d1_wr) d1_wr_cnt++;
   end

   task automatic send(input logic [W-1:0] r, input logic [4:0] f);
      res                  = r;
      {ef, nf, vf, cf, zf} = f;
      done                 = 1'b1;
      tick();
      done                 = 1'b0;
      res                  = W'($urandom);
      {ef, nf, vf, cf, zf} = 5'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (pending > 0 && n < 200) begin
         tick();
         n++;
      end
      check("idle_timeout", 32'(n < 200), 32'd1);
   endtask

   task automatic clear_fifo();
      fifo.delete();
      full = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      done    = 1'b0;
      res     = '0;
      {ef, nf, vf, cf, zf} = '0;
      full    = 1'b0;
      d1_done = 1'b0;
      d1_res  = '0;
      repeat (2) tick();
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_wr", 32'(wr), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_overrun", 32'(ovr), 32'h0);
      check("rst_d1_busy", 32'(d1_busy), 32'h0);
      rst = 1'b0;
      tick();

      // Basic frame
      send(8'h7E, 5'b00010);
      wait_idle();
      check("basic_size", fifo.size(), 2);
      if (fifo.size() == 2) begin
         check("basic_res", 32'(fifo[0]), 32'h7E);
         check("basic_sts", 32'(fifo[1]), 32'h02);
      end
      clear_fifo();

      // Zero / negative+overflow flags
      send(8'h00, 5'b00001);
      wait_idle();
      send(8'h81, 5'b01100);
      wait_idle();
      check("flags_size", fifo.size(), 4);
      if (fifo.size() == 4) begin
         check("flags_b0", 32'(fifo[0]), 32'h00);
         check("flags_b1", 32'(fifo[1]), 32'h01);
         check("flags_b2", 32'(fifo[2]), 32'h81);
         check("flags_b3", 32'(fifo[3]), 32'h0C);
      end
      clear_fifo();

      // Backpressure: three bytes preloaded, status must wait for a read
      fifo = '{8'hAA, 8'hBB, 8'hCC};
      full = 1'b0;
      send(8'h08, 5'b00000);
      repeat (5) tick();
      check("bp_full", 32'(full), 32'h1);
      check("bp_busy", 32'(busy), 32'h1);
      check("bp_res", 32'(fifo[3]), 32'h08);
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      wait_idle();
      repeat (3) tick();
      check("bp_size", fifo.size(), 4);
      if (fifo.size() == 4) begin
         check("bp_b0", 32'(fifo[0]), 32'hBB);
         check("bp_b2", 32'(fifo[2]), 32'h08);
         check("bp_b3", 32'(fifo[3]), 32'h00);
      end
      clear_fifo();

      // Overrun: second done one cycle after the first, exception frame
      res = 8'h11;
      {ef, nf, vf, cf, zf} = 5'b10000;
      done = 1'b1;
      tick();
      res = 8'h55;
      {ef, nf, vf, cf, zf} = 5'b00000;
      tick();
      done = 1'b0;
      wait_idle();
      repeat (3) tick();
      check("ovr_sticky", 32'(ovr), 32'h1);
      check("ovr_size", fifo.size(), 2);
      if (fifo.size() == 2) begin
         check("ovr_res", 32'(fifo[0]), 32'h11);
         check("ovr_sts", 32'(fifo[1]), 32'h10);
      end
      clear_fifo();

      // Async reset while in the status-byte state
      send(8'h33, 5'b00010);
      tick();
      rst = 1'b1;
      #1;
      check("arst_wr", 32'(wr), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_overrun", 32'(ovr), 32'h0);
      repeat (pending) void'(expq.pop_back());
      pending = 0;
      ovr_exp = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("arst_size", fifo.size(), 1);
      if (fifo.size() == 1) check("arst_res", 32'(fifo[0]), 32'h33);
      clear_fifo();
      send(8'h44, 5'b00011);
      wait_idle();
      check("arst_next_size", fifo.size(), 2);
      if (fifo.size() == 2) begin
         check("arst_next_res", 32'(fifo[0]), 32'h44);
         check("arst_next_sts", 32'(fifo[1]), 32'h03);
      end
      clear_fifo();

      // Randomised traffic with random reads and overlapping done strobes
      for (int i = 0; i < 400; i++) begin
         done                 = ($urandom_range(0, 2) == 0);
         res                  = W'($urandom);
         {ef, nf, vf, cf, zf} = 5'($urandom);
         rd_req               = ($urandom_range(0, 1) == 1);
         tick();
      end
      done   = 1'b0;
      rd_req = 1'b1;
      wait_idle();
      repeat (2) tick();
      check("expq_drained", expq.size(), 0);

      // Result-only variant
      d1_res  = 8'hA5;
      d1_done = 1'b1;
      tick();
      d1_done = 1'b0;
      check("sf0_busy", 32'(d1_busy), 32'h1);
      check("sf0_wr", 32'(d1_wr), 32'h1);
      check("sf0_data", 32'(d1_data), 32'hA5);
      tick();
      check("sf0_idle", 32'(d1_busy), 32'h0);
      check("sf0_no_wr", 32'(d1_wr), 32'h0);
      repeat (3) tick();
      check("sf0_wr_count", d1_wr_cnt, 1);
      check("sf0_hold", 32'(d1_data), 32'hA5);
      check("sf0_overrun", 32'(d1_ovr), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
